// File: rtl/p1v_reset_pkg.sv
// Shared types and constants for the p1v reset sequencer.
// Optional feature macro used by p1v_reset_ctrl: P1V_RESET_DEBOUNCE_EN (button debounce).
package p1v_reset_pkg;

    // Sequencer state: HOLD keeps the core in reset, RUN releases it.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } reset_state_t;

    // Source of the most recent reset; bit 0 = RTS, bit 1 = button.
    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_RTS  = 2'd1,
        CAUSE_BTN  = 2'd2,
        CAUSE_BOTH = 2'd3
    } reset_cause_t;

    // Default timing for a 160 MHz clock.
    localparam int DEFAULT_RTS_HOLD_CYCLES = 8_000_000;  // 50 ms
    localparam int DEFAULT_DEBOUNCE_CYCLES = 160_000;    // 1 ms
    localparam int DEFAULT_SYNC_STAGES     = 2;

    // Width of an unsigned counter that must hold 0..n; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/p1v_debounce.sv
// Button debouncer: the output follows an already-synchronized input only
// after the input has disagreed with the output for DEBOUNCE_CYCLES
// consecutive cycles. Any return to the current output value restarts the window.
// Instantiated by p1v_reset_ctrl only when P1V_RESET_DEBOUNCE_EN is defined.
module p1v_debounce
    import p1v_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic dout_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

    logic             dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    // Count consecutive cycles of disagreement; flip the output when the window completes.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        if (din_i != dout_q) begin
            if ((DEBOUNCE_CYCLES == 0) || (cnt_q == LAST_CNT)) begin
                dout_d = din_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output and timer registers; output resets to 0 (button reads as pressed).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/p1v_reset_ctrl.sv
// Reset sequencer ahead of the p1v core. Synchronizes the Prop Plug RTS line
// and the board button, stretches every release by RTS_HOLD_CYCLES (emulating
// the Prop Plug RC filter) and records which source caused the last reset.
// Optional feature macro: P1V_RESET_DEBOUNCE_EN routes the button through p1v_debounce.
module p1v_reset_ctrl
    import p1v_reset_pkg::*;
#(
    parameter int RTS_HOLD_CYCLES = DEFAULT_RTS_HOLD_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic       clock_160,
    input  logic       inp_resn,
    input  logic       rts,
    input  logic       reset,
    output logic       res_resn,
    output logic [1:0] res_cause
);

    localparam int CNT_W = cnt_width(RTS_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RTS_HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] rts_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   rts_s;
    logic                   btn_s;
    logic                   rts_req;
    logic                   btn_req;
    logic                   req;

    reset_state_t           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    reset_cause_t           cause_q, cause_d;
    logic                   res_resn_q;

    // Synchronizer chains; zero reset makes both lines read as requesting reset.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            rts_sync_q <= '0;
            btn_sync_q <= '0;
        end else begin
            rts_sync_q <= {rts_sync_q[SYNC_STAGES-2:0], rts};
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], reset};
        end
    end

    assign rts_s = rts_sync_q[SYNC_STAGES-1];

`ifdef P1V_RESET_DEBOUNCE_EN
    p1v_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clock_160),
        .rst_n  (inp_resn),
        .din_i  (btn_sync_q[SYNC_STAGES-1]),
        .dout_o (btn_s)
    );
`else
    assign btn_s = btn_sync_q[SYNC_STAGES-1];
`endif

    assign rts_req = ~rts_s;
    assign btn_req = ~btn_s;
    assign req     = rts_req | btn_req;

    // Next-state logic: reload while requested, count down after release, capture cause on entry to HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_HOLD: begin
                if (req) begin
                    cnt_d = HOLD_INIT;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (req) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                    cause_d = reset_cause_t'({btn_req, rts_req});
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_INIT;
            end
        endcase
    end

    // State, counter, cause and registered reset output.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q    <= ST_HOLD;
            cnt_q      <= HOLD_INIT;
            cause_q    <= CAUSE_POR;
            res_resn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            res_resn_q <= (state_d == ST_RUN);
        end
    end

    assign res_resn  = res_resn_q;
    assign res_cause = cause_q;

endmodule

// File: tb/tb_p1v_reset_ctrl.sv
// Self-checking bench for p1v_reset_ctrl. A reference model derives the
// expected outputs each clock from input history; a monitor compares them.
module tb_p1v_reset_ctrl;

    localparam int HOLD = 16;
    localparam int DB   = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       inp_resn;
    logic       rts;
    logic       reset;
    logic       res_resn;
    logic [1:0] res_cause;

    int checks = 0;
    int errors = 0;

    p1v_reset_ctrl #(
        .RTS_HOLD_CYCLES (HOLD),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clock_160 (clk),
        .inp_resn  (inp_resn),
        .rts       (rts),
        .reset     (reset),
        .res_resn  (res_resn),
        .res_cause (res_cause)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Expected output after each edge is {cause, resn}, pushed into exp_q.
    logic [2:0]  exp_q[$];
    logic        rts_hist[$];   // last SYNC samples of rts; front is the one the sequencer acts on
    logic        btn_hist[$];
    int          quiet_run;     // consecutive edges with no request seen
    logic        m_resn;
    logic [1:0]  m_cause;
    logic        db_val;
    int          db_run;

    task automatic model_reset();
        rts_hist.delete();
        btn_hist.delete();
        for (int i = 0; i < SYNC; i++) begin
            rts_hist.push_back(1'b0);
            btn_hist.push_back(1'b0);
        end
        quiet_run = 0;
        m_resn    = 1'b0;
        m_cause   = 2'd0;
        db_val    = 1'b0;
        db_run    = 0;
    endtask

    task automatic model_step();
        logic r_seen, b_sync, b_use, rq, new_resn;
        r_seen = rts_hist.pop_front();
        rts_hist.push_back(rts);
        b_sync = btn_hist.pop_front();
        btn_hist.push_back(reset);
`ifdef P1V_RESET_DEBOUNCE_EN
        b_use = db_val;
        if (b_sync != db_val) begin
            db_run++;
            if (db_run >= DB) begin
                db_val = b_sync;
                db_run = 0;
            end
        end else begin
            db_run = 0;
        end
`else
        b_use = b_sync;
`endif
        rq = !r_seen || !b_use;
        if (rq) quiet_run = 0;
        else if (quiet_run < HOLD + 1) quiet_run++;
        // Released once HOLD+1 consecutive request-free edges have been seen.
        new_resn = (quiet_run >= HOLD + 1);
        if (m_resn && !new_resn) m_cause = {!b_use, !r_seen};
        m_resn = new_resn;
        exp_q.push_back({m_cause, m_resn});
    endtask

    always @(posedge clk) begin
        if (!inp_resn) begin
            model_reset();
            exp_q.push_back(3'b000);
        end else begin
            model_step();
        end
    end

    // Asynchronous reset clears the model and any expectation already queued for this cycle.
    always @(negedge inp_resn) begin
        model_reset();
        foreach (exp_q[i]) exp_q[i] = 3'b000;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            if (res_resn !== e[0] || res_cause !== e[2:1]) begin
                errors++;
                $display("FAIL scoreboard t=%0t: res_resn got %0b want %0b, res_cause got %0d want %0d",
                         $time, res_resn, e[0], res_cause, e[2:1]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic b, input int n);
        rts   = r;
        reset = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; drops inp_resn mid-cycle and checks the output clears at once.
    task automatic async_pulse(input int hold_edges);
        #1 inp_resn = 1'b0;
        #1;
        check_val("async_resn", int'(res_resn), 0);
        check_val("async_cause", int'(res_cause), 0);
        repeat (hold_edges) @(posedge clk);
        #2 inp_resn = 1'b1;
    endtask

    initial begin
        int n;
        int exp_lat;
        inp_resn = 1'b0;
        rts      = 1'b1;
        reset    = 1'b1;

        // Power-on
        repeat (3) @(posedge clk);
        #1;
        check_val("por_resn_in_reset", int'(res_resn), 0);
        #1 inp_resn = 1'b1;
        n = 0;
        while (res_resn !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
`ifdef P1V_RESET_DEBOUNCE_EN
        exp_lat = SYNC + 1 + HOLD + DB;
`else
        exp_lat = SYNC + 1 + HOLD;
`endif
        check_val("por_release_latency", n, exp_lat);
        check_val("por_cause", int'(res_cause), 0);
        $display("scenario power-on: released after %0d edges", n);
        drive(1, 1, 5);

        // RTS pulse, then re-trigger during countdown
        drive(0, 1, 5);
        drive(1, 1, 10);
        check_val("rts_resn_low_in_countdown", int'(res_resn), 0);
        drive(0, 1, 1);
        drive(1, 1, 25);
        check_val("rts_cause", int'(res_cause), 1);
        check_val("rts_resn_after_hold", int'(res_resn), 1);
        $display("scenario rts pulse + retrigger: cause=%0d", res_cause);

        // Simultaneous RTS and button
        drive(0, 0, 10);
        drive(1, 1, 30);
        check_val("both_cause", int'(res_cause), 3);
        $display("scenario simultaneous: cause=%0d", res_cause);

        // Button only
        drive(1, 0, 10);
        drive(1, 1, 30);
        check_val("btn_cause", int'(res_cause), 2);
        $display("scenario button: cause=%0d", res_cause);

        // Async reset mid-countdown
        drive(0, 1, 3);
        drive(1, 1, 12);
        async_pulse(2);
        drive(1, 1, 30);
        check_val("async_recovered_resn", int'(res_resn), 1);
        $display("scenario async mid-countdown: recovered resn=%0b", res_resn);

        // Randomized segments
        for (int s = 0; s < 300; s++) begin
            drive(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 8),
                  int'($urandom_range(1, 22)));
            if ($urandom_range(0, 29) == 0) async_pulse(int'($urandom_range(1, 3)));
        end
        drive(1, 1, 40);
        $display("scenario random: done");

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
